// File: rtl/wb_pkg.sv
// Shared Wishbone widths, arbiter state encoding and a small index-width helper.
package wb_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Bits needed to hold a master index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester found searching upward
// from (last+1) mod NM with wrap.
module wb_rr_pick
  import wb_pkg::*;
#(
  parameter  int unsigned NM = 3,
  localparam int unsigned IW = idx_w(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NM-1:0] pick,
  output logic [IW-1:0] pick_idx,
  output logic          valid
);

  int unsigned cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    cand     = 0;
    for (int unsigned off = 1; off <= NM; off++) begin
      cand = (int'(last) + off) % NM;
      if (!valid && req[IW'(cand)]) begin
        valid            = 1'b1;
        pick[IW'(cand)]  = 1'b1;
        pick_idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter letting NM Wishbone masters share one slave port,
// with a stall watchdog that forces a bus error on a hung slave.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NM      = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NM-1:0]         m_cyc,
  input  logic [NM-1:0]         m_stb,
  input  logic [NM-1:0]         m_we,
  input  logic [SEL_W*NM-1:0]   m_sel,
  input  logic [ADR_W*NM-1:0]   m_adr,
  input  logic [DAT_W*NM-1:0]   m_dat_w,
  output logic [DAT_W*NM-1:0]   m_dat_r,
  output logic [NM-1:0]         m_ack,
  output logic [NM-1:0]         m_err,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [SEL_W-1:0]      s_sel,
  output logic [ADR_W-1:0]      s_adr,
  output logic [DAT_W-1:0]      s_dat_w,
  input  logic [DAT_W-1:0]      s_dat_r,
  input  logic                  s_ack,
  input  logic                  s_err,
  output logic [NM-1:0]         grant,
  output logic                  timeout
);

  localparam int unsigned IW = idx_w(NM);

  state_t           state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    last;
  logic [CNT_W-1:0] stall_cnt;

  logic [NM-1:0]    pick;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic             busy;
  logic             stalled;
  logic             force_err;

  wb_rr_pick #(.NM(NM)) u_pick (
    .req      (m_cyc),
    .last     (last),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  // rst gates the bus directly so a reset mid-transfer releases it at once.
  assign busy      = (state == BUSY) && !rst;
  assign stalled   = busy && s_stb && !(s_ack || s_err);
  assign force_err = stalled && (stall_cnt == CNT_W'(TIMEOUT));

  // Slave port follows the owner; grant is one-hot so the loop is a plain mux.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_adr   = '0;
    s_dat_w = '0;
    if (busy) begin
      for (int unsigned i = 0; i < NM; i++) begin
        if (grant[i]) begin
          s_cyc   = m_cyc[i];
          s_stb   = m_stb[i];
          s_we    = m_we[i];
          s_sel   = m_sel[i*SEL_W +: SEL_W];
          s_adr   = m_adr[i*ADR_W +: ADR_W];
          s_dat_w = m_dat_w[i*DAT_W +: DAT_W];
        end
      end
    end
  end

  always_comb begin
    m_ack = '0;
    m_err = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      m_ack[i] = busy && grant[i] && s_ack;
      m_err[i] = busy && grant[i] && (s_err || force_err);
    end
  end

  assign m_dat_r = {NM{s_dat_r}};

  // Arbitration state, ownership bookkeeping and stall watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= '0;
      last      <= IW'(NM - 1);
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= force_err;
      if (!stalled || force_err) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick;
            owner <= pick_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!m_cyc[owner]) begin
            last  <= owner;
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
